// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD1602 bus blocks: FSM states, default bus timing, RS encodings.
package lcd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETUP   = 3'd1,
        ST_EN_HI   = 3'd2,
        ST_HOLD    = 3'd3,
        ST_RECOVER = 3'd4
    } lcd_state_e;

    // Default phase lengths in 50 MHz cycles.
    localparam int LCD_T_AS     = 3;
    localparam int LCD_T_PW     = 25;
    localparam int LCD_T_AH     = 3;
    localparam int LCD_T_REC    = 25;
    localparam int LCD_POLL_MAX = 50000;

    localparam logic LCD_RS_INSTR = 1'b0;
    localparam logic LCD_RS_DATA  = 1'b1;

    // A phase of t cycles loads t-1 so the timer expires on the phase's last cycle.
    function automatic logic [4:0] phase_load(input int t);
        return 5'(t - 1);
    endfunction

endpackage

// File: rtl/lcd_phase_timer.sv
// Down-counter for bus phase timing: load a value, count to zero, expire while at zero.
module lcd_phase_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [4:0] load_val,
    output logic       expire
);

    logic [4:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (cnt_q != 5'd0) begin
            cnt_q <= cnt_q - 5'd1;
        end
    end

    assign expire = (cnt_q == 5'd0);

endmodule

// File: rtl/lcd_bus_reader.sv
// HD44780 read-cycle controller: busy-flag/address or data reads, with optional busy-flag polling.
module lcd_bus_reader
    import lcd_pkg::*;
#(
    parameter int T_AS     = LCD_T_AS,
    parameter int T_PW     = LCD_T_PW,
    parameter int T_AH     = LCD_T_AH,
    parameter int T_REC    = LCD_T_REC,
    parameter int POLL_MAX = LCD_POLL_MAX
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req,
    input  logic       rs_sel,
    input  logic       poll,
    output logic       busy,
    output logic       bus_own,
    output logic       done,
    output logic       timeout,
    output logic [7:0] rdata,
    output logic       bf,
    output logic [6:0] ac,
    output logic       LCD_EN,
    output logic       RS,
    output logic       RW,
    output logic       DB_OE,
    input  logic [7:0] DB_IN,
    output lcd_state_e state_dbg
);

    // Handshake: req is taken on any clock edge where busy=0; busy rises the next cycle and
    // stays high until the edge that raises done, so req while busy=1 is simply dropped.

    lcd_state_e  state_q, state_d;
    logic        rs_q, poll_q;
    logic [15:0] reads_q;
    logic [7:0]  rdata_q;
    logic        bf_q;
    logic [6:0]  ac_q;
    logic        done_q, timeout_q;

    logic        timer_load;
    logic [4:0]  timer_val;
    logic        timer_exp;
    logic        accept, sample, finish, finish_to;

    lcd_phase_timer u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (timer_load),
        .load_val (timer_val),
        .expire   (timer_exp)
    );

    always_comb begin
        state_d    = state_q;
        timer_load = 1'b0;
        timer_val  = 5'd0;
        accept     = 1'b0;
        sample     = 1'b0;
        finish     = 1'b0;
        finish_to  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    accept     = 1'b1;
                    state_d    = ST_SETUP;
                    timer_load = 1'b1;
                    timer_val  = phase_load(T_AS);
                end
            end
            ST_SETUP: begin
                if (timer_exp) begin
                    state_d    = ST_EN_HI;
                    timer_load = 1'b1;
                    timer_val  = phase_load(T_PW);
                end
            end
            ST_EN_HI: begin
                if (timer_exp) begin
                    sample     = 1'b1;
                    state_d    = ST_HOLD;
                    timer_load = 1'b1;
                    timer_val  = phase_load(T_AH);
                end
            end
            ST_HOLD: begin
                if (timer_exp) begin
                    state_d    = ST_RECOVER;
                    timer_load = 1'b1;
                    timer_val  = phase_load(T_REC);
                end
            end
            ST_RECOVER: begin
                if (timer_exp) begin
                    // bf_q already holds the busy flag from the read that just finished.
                    if (!poll_q || !bf_q) begin
                        finish  = 1'b1;
                        state_d = ST_IDLE;
                    end else if (reads_q >= 16'(POLL_MAX)) begin
                        finish    = 1'b1;
                        finish_to = 1'b1;
                        state_d   = ST_IDLE;
                    end else begin
                        state_d    = ST_SETUP;
                        timer_load = 1'b1;
                        timer_val  = phase_load(T_AS);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            rs_q      <= LCD_RS_INSTR;
            poll_q    <= 1'b0;
            reads_q   <= 16'd0;
            rdata_q   <= 8'h00;
            bf_q      <= 1'b0;
            ac_q      <= 7'd0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            done_q    <= finish;
            timeout_q <= finish_to;
            if (accept) begin
                rs_q    <= poll ? LCD_RS_INSTR : rs_sel;
                poll_q  <= poll;
                reads_q <= 16'd0;
            end
            if (sample) begin
                rdata_q <= DB_IN;
                if (rs_q == LCD_RS_INSTR) begin
                    bf_q <= DB_IN[7];
                    ac_q <= DB_IN[6:0];
                end
                if (reads_q != 16'hFFFF) begin
                    reads_q <= reads_q + 16'd1;
                end
            end
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign bus_own   = busy;
    assign RW        = busy;
    assign RS        = busy & rs_q;
    assign LCD_EN    = (state_q == ST_EN_HI);
    assign DB_OE     = 1'b0;
    assign done      = done_q;
    assign timeout   = timeout_q;
    assign rdata     = rdata_q;
    assign bf        = bf_q;
    assign ac        = ac_q;
    assign state_dbg = state_q;

endmodule
